decode: RTL and testbench
=========================

# decode

Combinational MIPS instruction decoder for the five-stage pipeline. Every stage that needs control signals instantiates its own copy and feeds it the instruction it currently holds. Examples: the register file uses the W-stage instruction for RegWrite, EXT uses the D-stage instruction for EXTOp, and NPC uses it for NPCOp. A small sticky error flag is the only state.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; used only by the sticky error flag.
- `reset`  in  1  reset, synchronous, active-high; clears `illegal_seen`.
- `instr`  in  32  instruction word to decode.
- `RegWrite`  out  1  instruction writes a GPR.
- `A3Sel`  out  2  destination register: 0 = rt, 1 = rd, 2 = $31.
- `WDSel`  out  2  write-back data: 0 = ALU result, 1 = memory data, 2 = PC+8.
- `ALUSrc`  out  1  ALU operand B: 0 = RD2, 1 = extended immediate.
- `ALUOp`  out  3  0 = add, 1 = sub, 2 = or.
- `MemWrite`  out  1  store to data memory.
- `EXTOp`  out  4  `zero_ext`, `sign_ext`, `tohigh_ext`, or `none_ext`.
- `NPCOp`  out  3  `seq_npc`, `bType_npc`, `jType_npc`, or `rType_npc`.
- `illegal`  out  1  combinational; high when the instruction is not recognised.
- `illegal_seen`  out  1  registered, sticky copy of `illegal`.

## Operation
- Fields: op = instr[31:26], funct = instr[5:0].
- Every output not listed for an instruction below is 0 (EXTOp = `none_ext`, NPCOp = `seq_npc`).
- Recognised instructions:
  - nop (instr == 32'h0): all controls 0.
  - addu (op 0, funct 0x21): RegWrite, A3Sel = rd, ALUOp = add.
  - subu (op 0, funct 0x23): RegWrite, A3Sel = rd, ALUOp = sub.
  - jr (op 0, funct 0x08): NPCOp = `rType_npc`.
  - ori (op 0x0D): RegWrite, A3Sel = rt, ALUSrc, ALUOp = or, EXTOp = `zero_ext`.
  - lui (op 0x0F): RegWrite, A3Sel = rt, ALUSrc, ALUOp = or, EXTOp = `tohigh_ext`. This relies on rs = $0.
  - lw (op 0x23): RegWrite, A3Sel = rt, WDSel = mem, ALUSrc, ALUOp = add, EXTOp = `sign_ext`.
  - sw (op 0x2B): MemWrite, ALUSrc, ALUOp = add, EXTOp = `sign_ext`.
  - beq (op 0x04): EXTOp = `sign_ext`, NPCOp = `bType_npc`.
  - j (op 0x02): NPCOp = `jType_npc`.
  - jal (op 0x03): RegWrite, A3Sel = $31, WDSel = PC+8, NPCOp = `jType_npc`.
- Any other encoding, including op 0 with any other funct and non-zero instr: all controls 0, `illegal` = 1.
- Decode is on opcode and funct only. No other fields are checked, e.g. shamt on addu is ignored.

## Timing
- All control outputs and `illegal` are purely combinational with zero latency; they are independent of `clk` and `reset`.
- `illegal_seen` on a rising `clk` edge:
  - reset = 1: cleared to 0; reset has priority over a simultaneous illegal instruction.
  - otherwise: illegal_seen <= illegal_seen | illegal.
- Reset value of `illegal_seen` is 0.

## Structure
- Shared package/header `define.v` holds all the codes:
  - EXTOp: `zero_ext` = 0, `sign_ext` = 1, `tohigh_ext` = 2, `none_ext` = 4'hF.
  - NPCOp: `seq_npc` = 0, `bType_npc` = 1, `jType_npc` = 2, `rType_npc` = 3.
  - ALUOp, A3Sel and WDSel codes.
  - Opcode and funct constants.
- Single module with no sub-modules.
- Implementation: a one-hot instruction-recognition layer, then an OR-of-instructions layer producing each control output.

## Test plan
- addu 0x00221821: RegWrite = 1, A3Sel = rd, ALUOp = add, ALUSrc = 0, NPCOp = `seq_npc`, illegal = 0.
- ori 0x34011234: EXTOp = `zero_ext`, ALUSrc = 1, ALUOp = or, A3Sel = rt. lui 0x3C01FFFF: EXTOp = `tohigh_ext`, RegWrite = 1.
- lw 0x8C220004: WDSel = mem, EXTOp = `sign_ext`, RegWrite = 1. sw 0xAC220004: MemWrite = 1, RegWrite = 0.
- beq 0x10220003: NPCOp = `bType_npc`, EXTOp = `sign_ext`, RegWrite = 0. j 0x08000C00: NPCOp = `jType_npc`, RegWrite = 0.
- jal 0x0C000C00: NPCOp = `jType_npc`, RegWrite = 1, A3Sel = $31, WDSel = PC+8. jr 0x03E00008: NPCOp = `rType_npc`, RegWrite = 0.
- Sticky flag sequence:
  - nop 0x00000000: every output 0.
  - 0xFC000000: `illegal` = 1 and `illegal_seen` = 1 after the next edge.
  - `illegal_seen` holds with legal instructions.
  - reset = 1 for one edge: `illegal_seen` = 0, even while 0xFC000000 is applied.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared control-code definitions for the pipeline decoders: selector encodings,
// EXT/NPC operation codes, and the MIPS opcode/funct constants.
package decode_pkg;

  typedef enum logic [3:0] {
    zero_ext   = 4'h0,
    sign_ext   = 4'h1,
    tohigh_ext = 4'h2,
    none_ext   = 4'hF
  } ext_op_e;

  typedef enum logic [2:0] {
    seq_npc   = 3'd0,
    bType_npc = 3'd1,
    jType_npc = 3'd2,
    rType_npc = 3'd3
  } npc_op_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  localparam logic [1:0] A3_RT = 2'd0;
  localparam logic [1:0] A3_RD = 2'd1;
  localparam logic [1:0] A3_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC8 = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

endpackage

// File: rtl/decode.sv
// Combinational MIPS control decoder. Each pipeline stage instantiates its own
// copy; the only state is a sticky flag recording any unrecognised instruction.
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        RegWrite,
  output logic [1:0]  A3Sel,
  output logic [1:0]  WDSel,
  output logic        ALUSrc,
  output logic [2:0]  ALUOp,
  output logic        MemWrite,
  output logic [3:0]  EXTOp,
  output logic [2:0]  NPCOp,
  output logic        illegal,
  output logic        illegal_seen
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_rtype;
  logic       w_nop, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
  logic       w_known;
  logic       r_illegal_seen;

  assign w_op    = instr[31:26];
  assign w_funct = instr[5:0];
  assign w_rtype = (w_op == OP_RTYPE);

  // One-hot recognition: at most one of these is high for any instruction word.
  assign w_nop  = (instr == 32'h0);
  assign w_addu = w_rtype && (w_funct == FN_ADDU);
  assign w_subu = w_rtype && (w_funct == FN_SUBU);
  assign w_jr   = w_rtype && (w_funct == FN_JR);
  assign w_ori  = (w_op == OP_ORI);
  assign w_lui  = (w_op == OP_LUI);
  assign w_lw   = (w_op == OP_LW);
  assign w_sw   = (w_op == OP_SW);
  assign w_beq  = (w_op == OP_BEQ);
  assign w_j    = (w_op == OP_J);
  assign w_jal  = (w_op == OP_JAL);

  assign w_known = w_nop | w_addu | w_subu | w_jr | w_ori | w_lui
                 | w_lw | w_sw | w_beq | w_j | w_jal;

  // OR-of-instructions layer; unrecognised words fall through to the defaults.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    RegWrite = 1'b0;
    A3Sel    = A3_RT;
    WDSel    = WD_ALU;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_ADD;
    MemWrite = 1'b0;
    EXTOp    = none_ext;
    NPCOp    = seq_npc;

    RegWrite = w_addu | w_subu | w_ori | w_lui | w_lw | w_jal;
    MemWrite = w_sw;
    ALUSrc   = w_ori | w_lui | w_lw | w_sw;

    if (w_addu | w_subu)              A3Sel = A3_RD;
    else if (w_jal)                   A3Sel = A3_RA;

    if (w_lw)                         WDSel = WD_MEM;
    else if (w_jal)                   WDSel = WD_PC8;

    if (w_subu)                       ALUOp = ALU_SUB;
    else if (w_ori | w_lui)           ALUOp = ALU_OR;

    if (w_ori)                        EXTOp = zero_ext;
    else if (w_lui)                   EXTOp = tohigh_ext;
    else if (w_lw | w_sw | w_beq)     EXTOp = sign_ext;

    if (w_beq)                        NPCOp = bType_npc;
    else if (w_j | w_jal)             NPCOp = jType_npc;
    else if (w_jr)                    NPCOp = rType_npc;
  end

  assign illegal = ~w_known;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_illegal_seen <= 1'b0;
    else       r_illegal_seen <= r_illegal_seen | illegal;
  end

  assign illegal_seen = r_illegal_seen;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: table of instruction vectors checked through a
// scoreboard queue, plus hand-written sequences for the sticky illegal flag.
module tb_decode;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] a3_sel;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_write;
    logic [3:0] ext_op;
    logic [2:0] npc_op;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    ctrl_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        RegWrite, ALUSrc, MemWrite, illegal, illegal_seen;
  logic [1:0]  A3Sel, WDSel;
  logic [2:0]  ALUOp, NPCOp;
  logic [3:0]  EXTOp;

  int n_compared   = 0;
  int n_mismatched = 0;
  ctrl_t exp_q[$];
  vec_t  vecs[$];

  decode dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .RegWrite     (RegWrite),
    .A3Sel        (A3Sel),
    .WDSel        (WDSel),
    .ALUSrc       (ALUSrc),
    .ALUOp        (ALUOp),
    .MemWrite     (MemWrite),
    .EXTOp        (EXTOp),
    .NPCOp        (NPCOp),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  always #5 clk = ~clk;

  function automatic ctrl_t mk(logic rw, logic [1:0] a3, logic [1:0] wd, logic src,
                               logic [2:0] alu, logic mw, logic [3:0] ext,
                               logic [2:0] npc, logic ill);
    ctrl_t c;
    c = '{rw, a3, wd, src, alu, mw, ext, npc, ill};
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [31:0] w, input ctrl_t exp);
    instr = w;
    exp_q.push_back(exp);
  endtask

  task automatic compare_out(input string name);
    ctrl_t act, exp;
    act = '{RegWrite, A3Sel, WDSel, ALUSrc, ALUOp, MemWrite, EXTOp, NPCOp, illegal};
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s: scoreboard empty, got 0x%0h, expected an entry", name, act);
    end else begin
      exp = exp_q.pop_front();
      check(name, 32'(act), 32'(exp));
    end
  endtask

  initial begin
    // Fields: rw, a3, wd, alusrc, aluop, memwrite, ext, npc, illegal
    vecs.push_back('{"addu",       32'h00221821, mk(1, 1, 0, 0, 0, 0, 4'hF, 0, 0)});
    vecs.push_back('{"addu_shamt", 32'h00221961, mk(1, 1, 0, 0, 0, 0, 4'hF, 0, 0)});
    vecs.push_back('{"subu",       32'h00221823, mk(1, 1, 0, 0, 1, 0, 4'hF, 0, 0)});
    vecs.push_back('{"jr",         32'h03E00008, mk(0, 0, 0, 0, 0, 0, 4'hF, 3, 0)});
    vecs.push_back('{"ori",        32'h34011234, mk(1, 0, 0, 1, 2, 0, 4'h0, 0, 0)});
    vecs.push_back('{"lui",        32'h3C01FFFF, mk(1, 0, 0, 1, 2, 0, 4'h2, 0, 0)});
    vecs.push_back('{"lw",         32'h8C220004, mk(1, 0, 1, 1, 0, 0, 4'h1, 0, 0)});
    vecs.push_back('{"sw",         32'hAC220004, mk(0, 0, 0, 1, 0, 1, 4'h1, 0, 0)});
    vecs.push_back('{"beq",        32'h10220003, mk(0, 0, 0, 0, 0, 0, 4'h1, 1, 0)});
    vecs.push_back('{"j",          32'h08000C00, mk(0, 0, 0, 0, 0, 0, 4'hF, 2, 0)});
    vecs.push_back('{"jal",        32'h0C000C00, mk(1, 2, 2, 0, 0, 0, 4'hF, 2, 0)});
    vecs.push_back('{"nop",        32'h00000000, mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0)});
    vecs.push_back('{"ill_op3f",   32'hFC000000, mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 1)});
    vecs.push_back('{"ill_sll",    32'h00011000, mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 1)});
    vecs.push_back('{"ill_add",    32'h00221820, mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 1)});
    vecs.push_back('{"ill_bne",    32'h14220003, mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 1)});

    reset = 1'b1;
    instr = 32'h0;
    repeat (2) @(posedge clk);
    #1 check("reset_seen", 32'(illegal_seen), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].exp);
      #1 compare_out(vecs[i].name);
    end

    // Sticky flag sequence from a clean reset.
    @(negedge clk);
    reset = 1'b1;
    instr = 32'h0;
    @(posedge clk);
    #1 check("seen_after_reset", 32'(illegal_seen), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h00000000, mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0));
    #1 compare_out("seq_nop");
    @(posedge clk);
    #1 check("seen_nop", 32'(illegal_seen), 32'd0);

    @(negedge clk);
    drive(32'hFC000000, mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 1));
    #1 compare_out("seq_illegal");
    check("seen_before_edge", 32'(illegal_seen), 32'd0);
    @(posedge clk);
    #1 check("seen_set", 32'(illegal_seen), 32'd1);

    @(negedge clk);
    instr = 32'h00221821;
    repeat (3) @(posedge clk);
    #1 check("seen_holds", 32'(illegal_seen), 32'd1);

    @(negedge clk);
    reset = 1'b1;
    instr = 32'hFC000000;
    @(posedge clk);
    #1 check("reset_beats_illegal", 32'(illegal_seen), 32'd0);
    check("illegal_during_reset", 32'(illegal), 32'd1);

    @(negedge clk);
    reset = 1'b0;
    instr = 32'h34011234;
    @(posedge clk);
    #1 check("seen_stays_clear", 32'(illegal_seen), 32'd0);

    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
